// File: rtl/wptr_full_ctrl_if.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl_if
//   Bundles the write-side status/pointer signals of the async FIFO write
//   controller. The controller uses the slave modport. The write client and
//   the read-pointer synchronizer use the master modport.
//
//   Signals (direction as seen by the controller / slave):
//     winc      in   write request, honoured only while wfull == 0
//     wq2_rptr  in   gray read pointer, already synchronized into wclk
//     wovf_clr  in   clears the sticky overflow flag
//     wfull     out  FIFO full (registered)
//     awfull    out  FIFO almost full (registered)
//     waddr     out  memory write address
//     wptr      out  registered gray write pointer, goes to the read domain
//     wlevel    out  conservative fill level, 0 .. 2**ADDRSIZE
//     wovf      out  sticky overflow flag
// ---------------------------------------------------------------------------
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = 4
) ();
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic                wfull;
  logic                awfull;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wfull, awfull, waddr, wptr, wlevel, wovf
  );

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wfull, awfull, waddr, wptr, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl
//   Write-side pointer and status controller for a dual-clock gray-pointer
//   async FIFO. It holds the binary write pointer and the gray write pointer
//   that is sent to the read domain. From the synchronized read pointer it
//   derives full, almost-full, a conservative fill level and a sticky
//   overflow flag. Everything here runs in the wclk domain.
//
//   Ports:
//     wclk    write-domain clock
//     wrst_n  asynchronous active-low reset
//     bus     wptr_full_ctrl_if.slave (winc, wq2_rptr, wovf_clr in;
//             wfull, awfull, waddr, wptr, wlevel, wovf out)
//
//   Parameters:
//     ADDRSIZE    address width, depth = 2**ADDRSIZE (>= 2)
//     AWFULLSIZE  almost-full margin, 1 .. 2**ADDRSIZE-1
//
//   Optional feature macro: WPTR_FULL_OVF_EN
//     defined   -> wovf is a sticky flag that sets on a write attempted while
//                  full, and clears on wovf_clr (a set wins over a clear).
//     undefined -> wovf is tied low and wovf_clr is ignored.
// ---------------------------------------------------------------------------
module wptr_full_ctrl #(
  parameter int ADDRSIZE   = 4,
  parameter int AWFULLSIZE = 1
) (
  input  logic              wclk,
  input  logic              wrst_n,
  wptr_full_ctrl_if.slave   bus
);

  localparam logic [ADDRSIZE:0] AWFULL_THRESH =
    (ADDRSIZE+1)'((1 << ADDRSIZE) - AWFULLSIZE);

  logic [ADDRSIZE:0] wbin_reg;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] wptr_reg;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] wlevel_reg;
  logic              wfull_reg;
  logic              awfull_reg;
  logic              wfull_val;
  logic              awfull_val;
  logic              winc_ok;

  // A write is accepted only while not full; the same term is the
  // external memory write enable.
  assign winc_ok    = bus.winc & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{ADDRSIZE{1'b0}}, winc_ok};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at and
  // above its position.
  generate
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_rbin
      assign rbin_s[gi] = ^bus.wq2_rptr[ADDRSIZE:gi];
    end
  endgenerate

  // Full when the next write pointer has lapped the read pointer by exactly
  // one depth: in gray code that is the top two bits inverted.
  assign wfull_val = (wgray_next ==
                      {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                        bus.wq2_rptr[ADDRSIZE-2:0]});

  // Modulo subtraction stays correct across pointer wrap; a stale read
  // pointer can only make this larger than the true occupancy.
  assign level_next = wbin_next - rbin_s;
  assign awfull_val = (level_next >= AWFULL_THRESH);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg   <= '0;
      wptr_reg   <= '0;
      wfull_reg  <= 1'b0;
      awfull_reg <= 1'b0;
      wlevel_reg <= '0;
    end else begin
      wbin_reg   <= wbin_next;
      wptr_reg   <= wgray_next;
      wfull_reg  <= wfull_val;
      awfull_reg <= awfull_val;
      wlevel_reg <= level_next;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  logic wovf_reg;

  // Set has priority so a dropped write is never lost to a concurrent clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_reg <= 1'b0;
    end else if (bus.winc & wfull_reg) begin
      wovf_reg <= 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_reg <= 1'b0;
    end
  end

  assign bus.wovf = wovf_reg;
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = bus.wovf_clr;
  assign bus.wovf       = 1'b0;
`endif

  assign bus.wfull  = wfull_reg;
  assign bus.awfull = awfull_reg;
  assign bus.waddr  = wbin_reg[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_reg;
  assign bus.wlevel = wlevel_reg;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

  localparam int A = 4;

`ifdef WPTR_FULL_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic wclk;
  logic wrst_n;
  int   n_cmp;
  int   n_bad;

  wptr_full_ctrl_if #(.ADDRSIZE(A)) bus ();

  wptr_full_ctrl #(
    .ADDRSIZE   (A),
    .AWFULLSIZE (1)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // new inputs are applied at the same point.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [A:0] to_gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset();
    wrst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wq2_rptr = '0;
    bus.wovf_clr = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.wptr !== 5'b00000) begin n_bad++; $display("FAIL reset_wptr got %b want 00000", bus.wptr); end
    n_cmp++;
    if (bus.waddr !== 4'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", bus.waddr); end
    n_cmp++;
    if ({bus.wfull, bus.awfull, bus.wovf} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got full/afull/ovf=%b want 000", {bus.wfull, bus.awfull, bus.wovf});
    end
    n_cmp++;
    if (bus.wlevel !== 5'd0) begin n_bad++; $display("FAIL reset_wlevel got %0d want 0", bus.wlevel); end
    wrst_n = 1'b1;
    $display("reset: wptr=%b wlevel=%0d", bus.wptr, bus.wlevel);
  endtask

  task automatic test_fill();
    bus.wq2_rptr = '0;
    bus.winc = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      n_cmp++;
      if (bus.wlevel !== 5'(i)) begin n_bad++; $display("FAIL fill_level[%0d] got %0d want %0d", i, bus.wlevel, i); end
      n_cmp++;
      if (bus.awfull !== (i >= 15)) begin n_bad++; $display("FAIL fill_awfull[%0d] got %b want %b", i, bus.awfull, i >= 15); end
      n_cmp++;
      if (bus.wfull !== 1'b0) begin n_bad++; $display("FAIL fill_wfull[%0d] got %b want 0", i, bus.wfull); end
      $display("fill write %0d: waddr=%0d wlevel=%0d awfull=%b", i, bus.waddr, bus.wlevel, bus.awfull);
    end
    n_cmp++;
    if (bus.waddr !== 4'd15) begin n_bad++; $display("FAIL fill_waddr15 got %0d want 15", bus.waddr); end
    step();
    n_cmp++;
    if (bus.wfull !== 1'b1) begin n_bad++; $display("FAIL full_wfull got %b want 1", bus.wfull); end
    n_cmp++;
    if (bus.wlevel !== 5'd16) begin n_bad++; $display("FAIL full_level got %0d want 16", bus.wlevel); end
    n_cmp++;
    if (bus.wptr !== 5'b11000) begin n_bad++; $display("FAIL full_wptr got %b want 11000", bus.wptr); end
    n_cmp++;
    if (bus.awfull !== 1'b1) begin n_bad++; $display("FAIL full_awfull got %b want 1", bus.awfull); end
    $display("write 16: wfull=%b wlevel=%0d wptr=%b", bus.wfull, bus.wlevel, bus.wptr);
  endtask

  task automatic test_overflow();
    bus.winc = 1'b1;
    step();
    n_cmp++;
    if (bus.wptr !== 5'b11000) begin n_bad++; $display("FAIL ovf_wptr_hold got %b want 11000", bus.wptr); end
    n_cmp++;
    if (bus.waddr !== 4'd0) begin n_bad++; $display("FAIL ovf_waddr_hold got %0d want 0", bus.waddr); end
    n_cmp++;
    if (bus.wfull !== 1'b1) begin n_bad++; $display("FAIL ovf_wfull got %b want 1", bus.wfull); end
    n_cmp++;
    if (bus.wovf !== OVF_ON) begin n_bad++; $display("FAIL ovf_set got %b want %b", bus.wovf, OVF_ON); end
    $display("dropped write: wptr=%b wovf=%b", bus.wptr, bus.wovf);
    bus.wovf_clr = 1'b1;
    step();
    n_cmp++;
    if (bus.wovf !== OVF_ON) begin n_bad++; $display("FAIL ovf_set_wins got %b want %b", bus.wovf, OVF_ON); end
    $display("clr+winc while full: wovf=%b", bus.wovf);
    bus.winc = 1'b0;
    step();
    n_cmp++;
    if (bus.wovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", bus.wovf); end
    n_cmp++;
    if (bus.wfull !== 1'b1) begin n_bad++; $display("FAIL ovf_idle_full got %b want 1", bus.wfull); end
    $display("clr alone: wovf=%b", bus.wovf);
    bus.wovf_clr = 1'b0;
  endtask

  task automatic test_read_advance();
    bus.winc = 1'b0;
    bus.wq2_rptr = 5'b00110;
    step();
    n_cmp++;
    if (bus.wfull !== 1'b0) begin n_bad++; $display("FAIL rd_wfull got %b want 0", bus.wfull); end
    n_cmp++;
    if (bus.awfull !== 1'b0) begin n_bad++; $display("FAIL rd_awfull got %b want 0", bus.awfull); end
    n_cmp++;
    if (bus.wlevel !== 5'd12) begin n_bad++; $display("FAIL rd_level got %0d want 12", bus.wlevel); end
    $display("read ptr gray 4: wfull=%b wlevel=%0d", bus.wfull, bus.wlevel);
    bus.winc = 1'b1;
    step();
    bus.winc = 1'b0;
    n_cmp++;
    if (bus.wlevel !== 5'd13) begin n_bad++; $display("FAIL rd_write_level got %0d want 13", bus.wlevel); end
    n_cmp++;
    if (bus.waddr !== 4'd1) begin n_bad++; $display("FAIL rd_write_waddr got %0d want 1", bus.waddr); end
    n_cmp++;
    if (bus.wptr !== 5'b11001) begin n_bad++; $display("FAIL rd_write_wptr got %b want 11001", bus.wptr); end
    $display("write after read: waddr=%0d wlevel=%0d", bus.waddr, bus.wlevel);
  endtask

  // Streams n writes starting from binary pointer start_bin while the read
  // pointer follows the write pointer one edge behind (two cycles from the
  // write that produced it to the DUT seeing it).
  task automatic test_stream(input int n, input logic [A:0] start_bin, output logic [A:0] end_bin);
    logic [A:0] exp_wbin;
    logic [A:0] rbin_used;
    logic [A:0] exp_level;
    logic       saw_wrap;
    exp_wbin  = start_bin;
    rbin_used = start_bin;
    saw_wrap  = 1'b0;
    bus.wq2_rptr = to_gray(rbin_used);
    bus.winc = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      exp_wbin  = exp_wbin + 1'b1;
      exp_level = exp_wbin - rbin_used;
      n_cmp++;
      if (bus.wptr !== to_gray(exp_wbin)) begin n_bad++; $display("FAIL stream_wptr[%0d] got %b want %b", i, bus.wptr, to_gray(exp_wbin)); end
      n_cmp++;
      if (bus.waddr !== exp_wbin[A-1:0]) begin n_bad++; $display("FAIL stream_waddr[%0d] got %0d want %0d", i, bus.waddr, exp_wbin[A-1:0]); end
      n_cmp++;
      if (bus.wlevel !== exp_level || bus.wlevel > 5'd2) begin
        n_bad++; $display("FAIL stream_level[%0d] got %0d want %0d", i, bus.wlevel, exp_level);
      end
      n_cmp++;
      if ({bus.wfull, bus.awfull} !== 2'b00) begin n_bad++; $display("FAIL stream_flags[%0d] got %b want 00", i, {bus.wfull, bus.awfull}); end
      if (exp_wbin == 5'd0) saw_wrap = 1'b1;
      $display("stream %0d: wptr=%b waddr=%0d wlevel=%0d", i, bus.wptr, bus.waddr, bus.wlevel);
      rbin_used = exp_wbin - 1'b1;
      bus.wq2_rptr = to_gray(rbin_used);
    end
    if (n >= 40) begin
      n_cmp++;
      if (saw_wrap !== 1'b1) begin n_bad++; $display("FAIL stream_wrap got %b want 1", saw_wrap); end
    end
    end_bin = exp_wbin;
  endtask

  task automatic test_reset_mid();
    bus.winc = 1'b1;
    @(posedge wclk);
    #2;
    wrst_n = 1'b0;
    bus.wq2_rptr = '0;
    #1;
    n_cmp++;
    if (bus.wptr !== 5'b00000 || bus.waddr !== 4'd0) begin
      n_bad++; $display("FAIL midrst_ptr got wptr=%b waddr=%0d want 00000/0", bus.wptr, bus.waddr);
    end
    n_cmp++;
    if ({bus.wfull, bus.awfull, bus.wovf} !== 3'b000 || bus.wlevel !== 5'd0) begin
      n_bad++; $display("FAIL midrst_status got flags=%b level=%0d want 000/0", {bus.wfull, bus.awfull, bus.wovf}, bus.wlevel);
    end
    step();
    wrst_n = 1'b1;
    $display("mid-stream reset: wptr=%b waddr=%0d", bus.wptr, bus.waddr);
    n_cmp++;
    if (bus.waddr !== 4'd0) begin n_bad++; $display("FAIL midrst_first_waddr got %0d want 0", bus.waddr); end
    step();
    bus.winc = 1'b0;
    n_cmp++;
    if (bus.wptr !== 5'b00001) begin n_bad++; $display("FAIL midrst_first_wptr got %b want 00001", bus.wptr); end
    n_cmp++;
    if (bus.wlevel !== 5'd1) begin n_bad++; $display("FAIL midrst_first_level got %0d want 1", bus.wlevel); end
    $display("first write after reset: wptr=%b wlevel=%0d", bus.wptr, bus.wlevel);
  endtask

  initial begin
    logic [A:0] bin_after;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_read_advance();
    // wbin is 17 here; 40 writes cross 31 -> 0, 16 more land on 9
    test_stream(40, 5'd17, bin_after);
    test_stream(16, bin_after, bin_after);
    n_cmp++;
    if (bin_after !== 5'd9) begin n_bad++; $display("FAIL stream_end_bin got %0d want 9", bin_after); end
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
